// File: rtl/hex_scan_if.sv
// Write/commit bus for the hex scan controller: shadow digit writes plus the
// commit request and its completion pulse.
interface hex_scan_if;
  // Handshake: a write (wr_en) or a commit is taken on any rising edge where
  // wr_ready is 1; with wr_ready at 0 both are dropped, never held or queued.
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_blank;
  logic       wr_ready;
  logic       commit;
  logic       commit_done;

  modport master (
    output wr_en, wr_addr, wr_data, wr_blank, commit,
    input  wr_ready, commit_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_blank, commit,
    output wr_ready, commit_done
  );
endinterface

// File: rtl/hex_scan_controller.sv
// Six-digit multiplexed 7-segment scanner with a shadow/active digit register
// pair; a commit copies shadow to active only at a frame boundary.
module hex_scan_controller #(
  parameter int DWELL = 50000,
  parameter int GAP   = 4
) (
  input  logic            clock,
  input  logic            resetn,
  hex_scan_if.slave       bus,
  output logic [6:0]      seg,
  output logic [5:0]      dig_en,
  output logic            frame_start,
  output logic [3:0]      state_dbg
);

  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_GAP = 1'b0, S_SHOW = 1'b1} scan_state_t;

  scan_state_t   state;
  logic [2:0]    ptr;
  logic [CW-1:0] cnt;
  logic          pending;
  logic          done_q;
  logic [4:0]    shadow [6];
  logic [4:0]    active [6];
  logic [4:0]    cur;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      default: r = 7'h0E;
    endcase
    return r;
  endfunction

  always_comb begin
    cur = 5'b10000;
    for (int i = 0; i < 6; i++) begin
      if (ptr == 3'(i)) cur = active[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= S_GAP;
      ptr     <= 3'd0;
      cnt     <= '0;
      pending <= 1'b0;
      done_q  <= 1'b0;
      seg     <= 7'h7F;
      dig_en  <= 6'b000000;
      for (int i = 0; i < 6; i++) begin
        shadow[i] <= 5'b10000;
        active[i] <= 5'b10000;
      end
    end else begin
      done_q <= 1'b0;
      if (bus.wr_en && !pending) begin
        for (int i = 0; i < 6; i++) begin
          if (bus.wr_addr == 3'(i)) shadow[i] <= {bus.wr_blank, bus.wr_data};
        end
      end
      // Boundary copy only clears a flag that was already set, so it never
      // races with a new commit (commits are refused while pending).
      if (bus.commit && !pending) pending <= 1'b1;

      if (state == S_GAP) begin
        if (cnt == CW'(GAP - 1)) begin
          state  <= S_SHOW;
          cnt    <= '0;
          dig_en <= 6'b000001 << ptr;
          seg    <= cur[4] ? 7'h7F : decode(cur[3:0]);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        if (cnt == CW'(DWELL - 1)) begin
          state  <= S_GAP;
          cnt    <= '0;
          seg    <= 7'h7F;
          dig_en <= 6'b000000;
          if (ptr == 3'd5) begin
            ptr <= 3'd0;
            if (pending) begin
              active  <= shadow;
              pending <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            ptr <= ptr + 3'd1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Qualified by resetn so the pulse stays low while reset is held.
  assign frame_start     = resetn && (state == S_GAP) && (ptr == 3'd0) && (cnt == '0);
  assign bus.wr_ready    = !pending;
  assign bus.commit_done = done_q;
  assign state_dbg       = {state == S_SHOW, ptr};

endmodule

// File: doc/hex_scan_controller.md
HEX_SCAN_CONTROLLER -- requirements
Module: hex_scan_controller

Interface
REQ-001 SHALL have parameter DWELL, default 50000, meaning SHOW cycles per digit (legal range >=1).
REQ-002 SHALL have parameter GAP, default 4, meaning blank cycles before each digit (legal range >=1).
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, meaning reset; synchronous, active-low.
REQ-005 SHALL have port wr_en, input, 1, meaning write request into the shadow digit register.
REQ-006 SHALL have port wr_addr, input, 3, meaning digit index 0..5.
REQ-007 SHALL have port wr_data, input, 4, meaning hex value 0..F.
REQ-008 SHALL have port wr_blank, input, 1, meaning mark the addressed digit blank.
REQ-009 SHALL have port wr_ready, output, 1, meaning writes and commits are accepted.
REQ-010 SHALL have port commit, input, 1, meaning request shadow-to-active copy at the next frame boundary.
REQ-011 SHALL have port commit_done, output, 1, meaning one-cycle pulse when the copy has taken effect.
REQ-012 SHALL have port seg, output, 7, meaning active-low segments {g,f,e,d,c,b,a} from one shared decoder.
REQ-013 SHALL have port dig_en, output, 6, meaning one-hot active-high digit enable.
REQ-014 SHALL have port frame_start, output, 1, meaning one-cycle pulse on the first GAP cycle of digit 0.

Function
REQ-015 SHALL hold a 6-entry shadow register and a 6-entry active register, each entry {blank,value[3:0]}.
REQ-016 SHALL update shadow[wr_addr] with {wr_blank,wr_data} on a cycle where wr_en=1 and wr_ready=1; wr_addr 6/7 SHALL have no effect; wr_en with wr_ready=0 SHALL be ignored.
REQ-017 SHALL run FSM states GAP and SHOW with a 3-bit digit pointer ptr, sequencing GAP(GAP cycles) -> SHOW(DWELL cycles) -> next digit's GAP.
REQ-018 SHALL advance ptr 0->1->...->5->0; the edge ending the last SHOW cycle of digit 5 is the frame boundary.
REQ-019 In GAP, SHALL drive seg=7'b1111111 and dig_en=0.
REQ-020 In SHOW, SHALL drive dig_en=1<<ptr, and seg=7'b1111111 if active[ptr].blank, else the decode of active[ptr].value.
REQ-021 SHALL decode values 0..F as 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, 7-bit active-low).
REQ-022 SHALL register seg and dig_en outputs with no glitches; the frame period SHALL be exactly 6*(GAP+DWELL) cycles.
REQ-023 SHALL set a pending flag on the edge where commit=1 and wr_ready=1; commit while pending SHALL merge (no extra effect).
REQ-024 SHALL drive wr_ready = NOT pending.
REQ-025 At a frame boundary with pending already set before that cycle, SHALL copy shadow to active and clear pending.
REQ-026 A commit first sampled in the boundary cycle itself SHALL defer to the following boundary.
REQ-027 A write accepted in the same cycle as commit SHALL be included in that commit.
REQ-028 In the cycle following a copy, SHALL assert commit_done=1 together with frame_start=1 and wr_ready=1; digit 0 SHOW of that frame SHALL use the new values.
REQ-029 Writes without commit SHALL never alter the display.

Reset
REQ-030 On a clock edge with resetn=0, SHALL set state=GAP, ptr=0, counters=0, pending=0, all shadow and active entries blank=1 and value=0.
REQ-031 During reset, SHALL drive seg=7F, dig_en=0, wr_ready=1, commit_done=0, frame_start=0.
REQ-032 The first cycle after resetn returns high SHALL be GAP cycle 1 of digit 0 with frame_start=1.
REQ-033 Reset mid-operation SHALL discard a pending commit without asserting commit_done.

Verification (DWELL=4, GAP=2, frame=36 cycles, cycle 0 = first cycle after reset)
REQ-034 Reset check: resetn=0 for 3 cycles -> seg=7F, dig_en=0, wr_ready=1; cycle 0 frame_start=1; cycles 0-1 dig_en=0; cycles 2-5 dig_en=000001 and seg=7F.
REQ-035 Commit check: write addr0=1 and addr5=F at cycle 3, commit at cycle 5 -> wr_ready=0 on cycles 6-35; cycle 36 shows commit_done=frame_start=1; cycles 38-41 show seg=79; cycles 68-71 show dig_en=100000 and seg=0E; other digits show 7F.
REQ-036 Shadow isolation check: write addr2=8 with no commit -> digit 2 remains 7F for 3 frames.
REQ-037 Boundary deferral check: commit at cycle 35 -> no commit_done at cycle 36; commit_done at cycle 72.
REQ-038 Blanking and address check: write addr0 data=8 with wr_blank=1, plus writes to addr 6/7, then commit -> digit 0 shows 7F; no digit changes from the addr 6/7 writes.
REQ-039 Mid-operation reset check: resetn=0 during digit 3 SHOW with commit pending -> next cycle shows reset outputs; commit_done is never asserted; the display stays fully blank.
